// File: rtl/mfcc_frame_pkg.sv
// Shared types and helpers for the MFCC framing controller.
package mfcc_frame_pkg;

   typedef enum logic [1:0] {
      S_FILL  = 2'd0,
      S_READ  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   // Circular-buffer pointer add; wraps by compare so size need not be a power of two.
   // Assumes ptr < size and inc <= size.
   function automatic logic [31:0] wrap_add(input logic [31:0] ptr,
                                            input logic [31:0] inc,
                                            input logic [31:0] size);
      logic [32:0] sum;
      sum = {1'b0, ptr} + {1'b0, inc};
      if (sum >= {1'b0, size}) sum = sum - {1'b0, size};
      return sum[31:0];
   endfunction

endpackage

// File: rtl/mfcc_skid_buf.sv
// Two-entry output buffer for frame read-back; occupancy feeds read-issue gating.
module mfcc_skid_buf #(
   parameter int W = 33
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic         valid,
   output logic [1:0]   occ
);

   logic [W-1:0] d0;
   logic [W-1:0] d1;
   logic         pop_en;

   assign pop_en = pop && (occ != 2'd0);
   assign head   = d0;
   assign valid  = (occ != 2'd0);

   // d0 is always the head; d1 only holds data while two entries are occupied.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d0  <= '0;
         d1  <= '0;
         occ <= 2'd0;
      end else if (clr) begin
         d0  <= '0;
         d1  <= '0;
         occ <= 2'd0;
      end else if (push && pop_en) begin
         if (occ == 2'd1) begin
            d0 <= push_data;
         end else begin
            d0 <= d1;
            d1 <= push_data;
         end
      end else if (push) begin
         if (occ == 2'd0) d0 <= push_data;
         else             d1 <= push_data;
         occ <= occ + 2'd1;
      end else if (pop_en) begin
         d0  <= d1;
         occ <= occ - 2'd1;
      end
   end

endmodule

// File: rtl/mfcc_frame_ctrl.sv
// MFCC framing controller: circular-buffer writer and overlapped frame reader
// on a single-port sample memory.
// Optional build macro MFCC_PREEMPH_EN: pre-emphasis (alpha = 31/32) on write data.
//
// state   | meaning
// S_FILL  | accepting samples until 'need' more have been written
// S_READ  | issuing FRAME_LEN reads from base, throttled by skid space
// S_DRAIN | waiting for the last sample to leave the skid buffer
import mfcc_frame_pkg::*;

module mfcc_frame_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 12,
   parameter int SIZE       = 4096,
   parameter int FRAME_LEN  = 400,
   parameter int HOP_LEN    = 160
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   output logic [15:0]           frame_cnt,
   output logic                  mem_cen,
   output logic                  mem_wen,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_data,
   input  logic [DATA_WIDTH-1:0] mem_q
);

   localparam int CW = $clog2(FRAME_LEN + 1);

   state_t                state;
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] base;
   logic [CW-1:0]         need;
   logic [CW-1:0]         rd_idx;
   logic                  inflight;
   logic                  inflight_last;
   logic [15:0]           fc;

   logic                  wr_fire;
   logic                  rd_issue;
   logic                  rd_last;
   logic                  pop;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [DATA_WIDTH-1:0] wdata;
   logic [1:0]            occ;
   logic                  skid_valid;
   logic [DATA_WIDTH:0]   skid_head;

   assign in_ready = !rst && !clr && (state == S_FILL) && (need != '0);
   assign wr_fire  = in_valid && in_ready;
   assign pop      = skid_valid && out_ready;
   assign rd_last  = (rd_idx == CW'(FRAME_LEN - 1));
   assign rd_addr  = ADDR_WIDTH'(wrap_add(32'(base), 32'(rd_idx), 32'(SIZE)));

   // Space check counts the entry leaving this cycle so an unstalled stream runs at one word per cycle.
   assign rd_issue = !clr && (state == S_READ) &&
                     ((3'(occ) + 3'(inflight) - 3'(pop)) < 3'd2);

   assign mem_cen  = wr_fire || rd_issue;
   assign mem_wen  = wr_fire;
   assign mem_addr = wr_fire ? wr_ptr : (rd_issue ? rd_addr : '0);
   assign mem_data = wr_fire ? wdata : '0;

   assign out_valid = skid_valid;
   assign out_data  = skid_head[DATA_WIDTH-1:0];
   assign out_last  = skid_head[DATA_WIDTH];
   assign frame_cnt = fc;

`ifdef MFCC_PREEMPH_EN
   localparam logic signed [DATA_WIDTH+1:0] SAT_MAX = {3'b000, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [DATA_WIDTH+1:0] SAT_MIN = {3'b111, {(DATA_WIDTH-1){1'b0}}};

   logic [DATA_WIDTH-1:0]        x_prev;
   logic signed [DATA_WIDTH+1:0] y_ext;

   // Previous accepted sample; x[-1] is zero after reset or clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)          x_prev <= '0;
      else if (clr)     x_prev <= '0;
      else if (wr_fire) x_prev <= in_data;
   end

   // y = x - x_prev + (x_prev >>> 5), saturated to the signed sample range.
   always_comb begin
      y_ext = {{2{in_data[DATA_WIDTH-1]}}, in_data}
            - {{2{x_prev[DATA_WIDTH-1]}}, x_prev}
            + {{7{x_prev[DATA_WIDTH-1]}}, x_prev[DATA_WIDTH-1:5]};
      if (y_ext > SAT_MAX)      wdata = SAT_MAX[DATA_WIDTH-1:0];
      else if (y_ext < SAT_MIN) wdata = SAT_MIN[DATA_WIDTH-1:0];
      else                      wdata = y_ext[DATA_WIDTH-1:0];
   end
`else
   assign wdata = in_data;
`endif

   mfcc_skid_buf #(.W(DATA_WIDTH + 1)) u_skid (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .push      (inflight),
      .push_data ({inflight_last, mem_q}),
      .pop       (out_ready),
      .head      (skid_head),
      .valid     (skid_valid),
      .occ       (occ)
   );

   // Framing FSM: fill, read back, drain, then advance base by one hop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= S_FILL;
         wr_ptr        <= '0;
         base          <= '0;
         need          <= CW'(FRAME_LEN);
         rd_idx        <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
         fc            <= '0;
      end else if (clr) begin
         state         <= S_FILL;
         wr_ptr        <= '0;
         base          <= '0;
         need          <= CW'(FRAME_LEN);
         rd_idx        <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
         fc            <= '0;
      end else begin
         inflight      <= rd_issue;
         inflight_last <= rd_issue && rd_last;
         case (state)
            S_FILL: begin
               if (wr_fire) begin
                  wr_ptr <= ADDR_WIDTH'(wrap_add(32'(wr_ptr), 32'd1, 32'(SIZE)));
                  need   <= need - CW'(1);
                  if (need == CW'(1)) begin
                     state  <= S_READ;
                     rd_idx <= '0;
                  end
               end
            end
            S_READ: begin
               if (rd_issue) begin
                  rd_idx <= rd_idx + CW'(1);
                  if (rd_last) state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (!skid_valid && !inflight) begin
                  fc    <= fc + 16'd1;
                  base  <= ADDR_WIDTH'(wrap_add(32'(base), 32'(HOP_LEN), 32'(SIZE)));
                  need  <= CW'(HOP_LEN);
                  state <= S_FILL;
               end
            end
            default: state <= S_FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_mfcc_frame_ctrl.sv
// Directed testbench for mfcc_frame_ctrl (SIZE=16, FRAME_LEN=8, HOP_LEN=4).
module tb_mfcc_frame_ctrl;

   localparam int DW = 32;
   localparam int AW = 4;
   localparam int SZ = 16;
   localparam int FL = 8;
   localparam int HL = 4;

   logic          clk;
   logic          rst;
   logic          clr;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic [15:0]   frame_cnt;
   logic          mem_cen;
   logic          mem_wen;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data;
   logic [DW-1:0] mem_q;

   logic [DW-1:0] mem [0:SZ-1];

   int n_cmp = 0;
   int n_err = 0;
   int exp_wr = 0;
   int exp_base = 0;
   int exp_fc = 0;
   int lat_first;
   int lat_last;
   bit [4:0] pat = 5'b01001;

   mfcc_frame_ctrl #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .SIZE       (SZ),
      .FRAME_LEN  (FL),
      .HOP_LEN    (HL)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .frame_cnt (frame_cnt),
      .mem_cen   (mem_cen),
      .mem_wen   (mem_wen),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .mem_q     (mem_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-port memory with one-cycle read latency
   always @(posedge clk) begin
      if (mem_cen) begin
         if (mem_wen) mem[mem_addr] <= mem_data;
         else         mem_q <= mem[mem_addr];
      end
   end

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Push n consecutive samples, checking each write on the memory pins
   task automatic feed(input int first, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = 32'(first + i);
         #1;
         chk_eq("wr_ready", 32'(in_ready), 32'd1);
         chk_eq("wr_cen",   32'(mem_cen),  32'd1);
         chk_eq("wr_wen",   32'(mem_wen),  32'd1);
         chk_eq($sformatf("wr_addr_%0d", first + i), 32'(mem_addr), 32'(exp_wr));
         chk_eq($sformatf("wr_data_%0d", first + i), mem_data, 32'(first + i));
         @(posedge clk);
         exp_wr = (exp_wr + 1) % SZ;
      end
   endtask

   // Read back one frame expected as first..first+7; mode 1 applies backpressure;
   // clr_at >= 0 pulses clr while that output index is presented.
   task automatic collect(input int first, input int mode, input int clr_at);
      int k = 0;
      int cyc = 0;
      int issued = 0;
      int max_out = 0;
      int extra = 0;
      logic hold = 1'b0;
      logic [DW-1:0] hd = '0;
      logic hl = 1'b0;
      lat_first = -1;
      lat_last = -1;
      while (k < FL && cyc < 100) begin
         @(negedge clk);
         in_valid  = 1'b0;
         out_ready = (mode == 0) ? 1'b1 : pat[cyc % 5];
         #1;
         if (cyc == 0) chk_eq("ready_low_after_fill", 32'(in_ready), 32'd0);
         if (hold) begin
            chk_eq("hold_valid", 32'(out_valid), 32'd1);
            chk_eq("hold_data",  out_data, hd);
            chk_eq("hold_last",  32'(out_last), 32'(hl));
         end
         if (mem_cen && !mem_wen) begin
            chk_eq($sformatf("rd_addr_%0d", issued), 32'(mem_addr), 32'((exp_base + issued) % SZ));
            issued++;
         end
         if (out_valid && clr_at == k) begin
            clr = 1'b1;
            @(negedge clk);
            clr = 1'b0;
            #1;
            chk_eq("clr_out_valid", 32'(out_valid), 32'd0);
            chk_eq("clr_frame_cnt", 32'(frame_cnt), 32'd0);
            chk_eq("clr_in_ready",  32'(in_ready),  32'd1);
            exp_wr = 0;
            exp_base = 0;
            exp_fc = 0;
            return;
         end
         if (out_valid && lat_first < 0) lat_first = cyc;
         if (out_valid && out_ready) begin
            chk_eq($sformatf("out_data_%0d", k), out_data, 32'(first + k));
            chk_eq($sformatf("out_last_%0d", k), 32'(out_last), 32'(k == FL - 1));
            k++;
            lat_last = cyc;
            hold = 1'b0;
         end else if (out_valid) begin
            hold = 1'b1;
            hd = out_data;
            hl = out_last;
         end else begin
            hold = 1'b0;
         end
         if (issued - k > max_out) max_out = issued - k;
         cyc++;
      end
      chk_eq("frame_samples", 32'(k), 32'(FL));
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         if (out_valid || mem_cen) extra++;
      end
      chk_eq("no_extra_activity", 32'(extra), 32'd0);
      chk_eq("reads_issued", 32'(issued), 32'(FL));
      chk_eq("max_outstanding_le2", 32'(max_out <= 2), 32'd1);
      exp_fc++;
      chk_eq("frame_cnt", 32'(frame_cnt), 32'(exp_fc));
      exp_base = (exp_base + HL) % SZ;
   endtask

   initial begin
      rst = 1'b1;
      clr = 1'b0;
      in_valid = 1'b0;
      in_data = '0;
      out_ready = 1'b0;
      #12;
      chk_eq("rst_in_ready",  32'(in_ready),  32'd0);
      chk_eq("rst_out_valid", 32'(out_valid), 32'd0);
      chk_eq("rst_mem_cen",   32'(mem_cen),   32'd0);
      chk_eq("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk_eq("rel_in_ready", 32'(in_ready), 32'd1);

      // First frame with unstalled output: latency and throughput
      feed(1, 8);
      collect(1, 0, -1);
      chk_eq("first_out_latency", 32'(lat_first), 32'd2);
      chk_eq("last_out_cycle",    32'(lat_last),  32'd9);

      // Hops, with the last frame wrapping 15 -> 0
      feed(9, 4);
      collect(5, 0, -1);
      feed(13, 4);
      collect(9, 0, -1);
      feed(17, 4);
      collect(13, 0, -1);
      chk_eq("frame_cnt_4", 32'(frame_cnt), 32'd4);

      // Backpressure pattern 1,0,0,1,0 repeating
      feed(21, 4);
      collect(17, 1, -1);

      // Asynchronous reset asserted mid-cycle
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk_eq("arst_out_valid", 32'(out_valid), 32'd0);
      chk_eq("arst_out_data",  out_data,       32'd0);
      chk_eq("arst_out_last",  32'(out_last),  32'd0);
      chk_eq("arst_in_ready",  32'(in_ready),  32'd0);
      chk_eq("arst_mem_cen",   32'(mem_cen),   32'd0);
      chk_eq("arst_mem_addr",  32'(mem_addr),  32'd0);
      chk_eq("arst_frame_cnt", 32'(frame_cnt), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk_eq("arst_rel_in_ready", 32'(in_ready), 32'd1);
      exp_wr = 0;
      exp_base = 0;
      exp_fc = 0;

      // clr on the 3rd output of frame 2, then a fresh 8-sample frame from address 0
      feed(1, 8);
      collect(1, 0, -1);
      feed(9, 4);
      collect(5, 0, 2);
      feed(101, 8);
      collect(101, 0, -1);

`ifdef MFCC_PREEMPH_EN
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      in_valid = 1'b1;
      in_data = 32'd100;
      #1;
      chk_eq("pre_0", mem_data, 32'd100);
      @(negedge clk);
      in_data = 32'd100;
      #1;
      chk_eq("pre_1", mem_data, 32'd3);
      @(negedge clk);
      in_data = 32'h8000_0000;
      #1;
      chk_eq("pre_2_sat", mem_data, 32'h8000_0000);
      @(negedge clk);
      in_valid = 1'b0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mfcc_frame_ctrl.md
Name: mfcc_frame_ctrl

Overview:
- Framing stage directly upstream of the sample memory: accepts a stream of audio samples and writes them into a circular buffer in the single-port sample memory.
- Once a full frame is present, reads it back as an ordered stream of FRAME_LEN samples for the FFT/window stage.
- Consecutive frames overlap by FRAME_LEN-HOP_LEN samples.
- Owns the memory's cen/wen/addr/data pins.

Parameters:
- DATA_WIDTH, 32, sample and memory word width.
- ADDR_WIDTH, 12, memory address width.
- SIZE, 4096, circular buffer depth in words; need not be a power of two.
- FRAME_LEN, 400, samples per frame; 1 <= FRAME_LEN <= SIZE.
- HOP_LEN, 160, frame advance; 1 <= HOP_LEN <= FRAME_LEN.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous soft clear; same effect as reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  input sample accepted when in_valid && in_ready.
- in_data  in  DATA_WIDTH  input sample.
- out_valid  out  1  frame sample valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_WIDTH  frame sample.
- out_last  out  1  marks sample FRAME_LEN-1 of a frame.
- frame_cnt  out  16  completed frames, wraps at 65535->0.
- mem_cen  out  1  memory enable, 1 = access.
- mem_wen  out  1  1 = write, 0 = read; valid only with mem_cen=1.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_data  out  DATA_WIDTH  write data.
- mem_q  in  DATA_WIDTH  read data, valid the cycle after a read is issued.

Behaviour:
- Reset / clr: all outputs 0 (in_ready=0 during rst; 1 the first cycle after). Pointers wr_ptr=base=0, need=FRAME_LEN, state S_FILL, skid buffer emptied, any in-flight read discarded. clr overrides all other events in its cycle.
- S_FILL:
  - in_ready=1.
  - Each handshake issues a write the same cycle: mem_cen=1, mem_wen=1, mem_addr=wr_ptr, mem_data=sample. wr_ptr advances, wrapping SIZE-1 -> 0 by compare, not modulo.
  - need decrements per write. When need reaches 0 (the write that makes it 0 is completed), move to S_READ.
  - in_ready drops combinationally when need==0.
- S_READ:
  - in_ready=0. A read counter rd_idx runs 0..FRAME_LEN-1 at address (base+rd_idx) wrapped.
  - A read is issued (mem_cen=1, mem_wen=0) only if skid occupancy plus in-flight count < 2. mem_q is captured into the skid buffer the next cycle.
  - After the last read is issued, move to S_DRAIN.
  - mem_cen=0 on idle cycles.
- S_DRAIN:
  - Wait until the skid buffer is empty and the last sample has been accepted.
  - Then frame_cnt+1, base advances by HOP_LEN (wrapped), need=HOP_LEN, back to S_FILL.
- Output stream:
  - out_data/out_last come from the 2-entry skid buffer head. out_valid = buffer non-empty.
  - out_data and out_last hold stable while out_valid && !out_ready.
  - out_last is asserted with the sample whose rd_idx == FRAME_LEN-1.
- Throughput: one sample per cycle each direction when unstalled. First output appears 2 cycles after the final fill write.
- Wrap-around: both pointers wrap independently; a frame may span address SIZE-1 -> 0.
- Hazards: reads and writes never overlap, so there is no read/write collision on the single port.

Optional Feature:
- MFCC_PREEMPH_EN defined: write data is pre-emphasised, y[n] = x[n] - x[n-1] + (x[n-1] >>> 5) (alpha = 31/32).
  - Signed arithmetic, DATA_WIDTH+2 internal width, saturated to the DATA_WIDTH signed range.
  - x[-1] = 0 after reset/clr. x[n-1] updates only on handshake.
- Undefined: mem_data = in_data unchanged.

Decomposition:
- Package mfcc_frame_pkg: state enum (S_FILL, S_READ, S_DRAIN), and a wrap-add function taking pointer, increment, and SIZE.
- Sub-module mfcc_skid_buf: 2-entry valid/ready buffer with occupancy output used for read-issue gating.

Test Plan (SIZE=16, FRAME_LEN=8, HOP_LEN=4, feature off unless noted):
1. Reset: assert rst mid-cycle -> all outputs 0 asynchronously; in_ready=1 the cycle after release.
2. First frame: feed 1..8 back-to-back -> 8 writes to addr 0..7, in_ready=0 after the 8th. Output 1..8, out_last on 8, frame_cnt=1.
3. Hop plus wrap: feed 9..12, then 13..16, then 17..20 -> frames 5..12, 9..16, 13..20. The last frame reads addr 12..15, 0..3; frame_cnt=4.
4. Backpressure: out_ready pattern 1,0,0,1,0,1... during a frame -> exactly 8 samples in order, no duplicates, data held while stalled, never more than 2 reads outstanding.
5. clr on 3rd output of frame 2 -> out_valid=0 the next cycle, frame_cnt=0. The next frame requires 8 fresh samples and starts at addr 0.
6. MFCC_PREEMPH_EN defined: inputs 100, 100, -2147483648 -> mem_data 100, 3, then saturated to -2147483648.
